// File: rtl/tt_vector_checker.sv
// Pattern-RAM driven stimulus/response checker: issues stimulus words, compares
// masked DUT responses LATENCY cycles later and reports pass/fail statistics.
module tt_vector_checker #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_stim,
  input  logic [DATA_W-1:0] load_exp,
  input  logic [DATA_W-1:0] load_mask,
  input  logic [AW:0]       num_vec,
  input  logic              start,
  output logic [DATA_W-1:0] stim_out,
  input  logic [DATA_W-1:0] dut_resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [AW-1:0]     first_err_idx
);

  localparam int        TAIL    = LATENCY - 1;
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] ram_stim [DEPTH];
  logic [DATA_W-1:0] ram_exp  [DEPTH];
  logic [DATA_W-1:0] ram_mask [DEPTH];

  logic              vld_p  [LATENCY];
  logic              last_p [LATENCY];
  logic [DATA_W-1:0] exp_p  [LATENCY];
  logic [DATA_W-1:0] mask_p [LATENCY];
  logic [AW-1:0]     idx_p  [LATENCY];

  logic [AW:0]      n_q, issue_cnt, n_eff;
  logic [AW-1:0]    rd_idx;
  logic             idle_like, accept_start, issue, issue_last;
  logic             mismatch, last_cmp;
  logic [CNT_W-1:0] err_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign idle_like    = (state == IDLE) || (state == DONE);
  assign accept_start = start && idle_like;
  assign n_eff        = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign issue        = (state == RUN);
  assign issue_last   = issue && (issue_cnt == n_q - (AW+1)'(1));
  assign rd_idx       = issue_cnt[AW-1:0];
  assign mismatch     = vld_p[TAIL] && (((dut_resp ^ exp_p[TAIL]) & mask_p[TAIL]) != '0);
  assign last_cmp     = vld_p[TAIL] && last_p[TAIL];
  assign err_nx       = mismatch ? sat_inc(err_count) : err_count;
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);

  // Writes land on the start edge, so a simultaneous load is seen by the run.
  always_ff @(posedge clk) begin
    if (load_en && idle_like && ({1'b0, load_addr} < DEPTH_N)) begin
      ram_stim[load_addr] <= load_stim;
      ram_exp[load_addr]  <= load_exp;
      ram_mask[load_addr] <= load_mask;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (n_eff == '0) ? DONE : RUN;
      RUN:        if (issue_last) state_nx = DRAIN;
      DRAIN:      if (last_cmp) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Stage p0..p(LATENCY-1): compare data follows its stimulus word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_p[0]  <= ram_exp[rd_idx];
    mask_p[0] <= ram_mask[rd_idx];
    idx_p[0]  <= rd_idx;
    last_p[0] <= issue_last;
    for (int i = 1; i < LATENCY; i++) begin
      exp_p[i]  <= exp_p[i-1];
      mask_p[i] <= mask_p[i-1];
      idx_p[i]  <= idx_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  // Compare stage: results update at the pipe tail
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      n_q             <= '0;
      issue_cnt       <= '0;
      stim_out        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      pass            <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept_start) begin
        n_q             <= n_eff;
        issue_cnt       <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
        pass            <= (n_eff == '0);
      end else begin
        if (issue) begin
          stim_out  <= ram_stim[rd_idx];
          issue_cnt <= issue_cnt + (AW+1)'(1);
        end
        if (mismatch) begin
          err_count <= err_nx;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= idx_p[TAIL];
          end
        end
        if (last_cmp) pass <= (err_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_tt_vector_checker.sv
// Randomised and directed bench for tt_vector_checker against a per-run
// reference computed from the vector table and the response table.
module tb_tt_vector_checker;
  localparam int DW = 8, DEPTH = 16, LAT = 2, CW = 2, AW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, load_en, start;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_stim, load_exp, load_mask, dut_resp, stim_out;
  logic [AW:0]   num_vec;
  logic          busy, done, pass, first_err_valid;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_idx;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_stim [DEPTH];
  logic [DW-1:0] m_exp  [DEPTH];
  logic [DW-1:0] m_mask [DEPTH];
  logic [DW-1:0] resp   [DEPTH];
  logic [DW-1:0] wf_stim, wf_exp, wf_mask;

  tt_vector_checker #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .num_vec(num_vec), .start(start), .stim_out(stim_out), .dut_resp(dut_resp),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input int a, input logic [DW-1:0] s, input logic [DW-1:0] e,
                      input logic [DW-1:0] m);
    @(negedge clk);
    load_en = 1'b1; load_addr = a[AW-1:0]; load_stim = s; load_exp = e; load_mask = m;
    @(negedge clk);
    load_en = 1'b0;
    m_stim[a] = s; m_exp[a] = e; m_mask[a] = m;
  endtask

  // Runs nv vectors with responses taken from resp[], checking timing, stimulus
  // sequence and final statistics against values derived from the tables.
  task automatic do_run(input int nv, input bit poke, input bit wf, input string tag);
    int n, exp_err, first, done_at, k;
    bit timing_bad, stim_bad;
    logic [DW-1:0] es;
    if (wf) begin
      m_stim[0] = wf_stim; m_exp[0] = wf_exp; m_mask[0] = wf_mask;
    end
    n = (nv > DEPTH) ? DEPTH : nv;
    exp_err = 0; first = -1;
    for (int j = 0; j < n; j++)
      if (((resp[j] ^ m_exp[j]) & m_mask[j]) != 0) begin
        if (exp_err < SAT) exp_err++;
        if (first < 0) first = j;
      end
    @(negedge clk);
    num_vec = nv[AW:0]; start = 1'b1;
    if (wf) begin
      load_en = 1'b1; load_addr = '0; load_stim = wf_stim; load_exp = wf_exp; load_mask = wf_mask;
    end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    done_at = (n == 0) ? 0 : n + LAT;
    timing_bad = 1'b0; stim_bad = 1'b0;
    for (int c = 0; c <= done_at + 2; c++) begin
      if (done !== (c >= done_at)) timing_bad = 1'b1;
      if (busy !== (c < done_at)) timing_bad = 1'b1;
      if (n > 0 && c >= 1) begin
        es = m_stim[(c - 1 < n - 1) ? c - 1 : n - 1];
        if (stim_out !== es) stim_bad = 1'b1;
      end
      k = c - LAT;
      dut_resp = (k >= 0 && k < n) ? resp[k] : DW'($urandom);
      if (poke && c == 1) begin
        load_en = 1'b1; load_addr = '0; load_stim = ~m_stim[0]; load_exp = ~m_exp[0];
        load_mask = 8'hFF; start = 1'b1; num_vec = '0;
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    n_assert++;
    if (timing_bad) begin
      n_fail++; $display("FAIL %s busy/done timing: wrong at some cycle, required done after %0d cycles", tag, done_at);
    end
    n_assert++;
    if (stim_bad) begin
      n_fail++; $display("FAIL %s stim_out sequence: got %h at end, required vector sequence of %0d", tag, stim_out, n);
    end
    n_assert++;
    if (err_count !== CW'(exp_err)) begin
      n_fail++; $display("FAIL %s err_count: got %0d required %0d", tag, err_count, exp_err);
    end
    n_assert++;
    if (first_err_valid !== (first >= 0)) begin
      n_fail++; $display("FAIL %s first_err_valid: got %0d required %0d", tag, first_err_valid, first >= 0);
    end
    if (first >= 0) begin
      n_assert++;
      if (first_err_idx !== AW'(first)) begin
        n_fail++; $display("FAIL %s first_err_idx: got %0d required %0d", tag, first_err_idx, first);
      end
    end
    n_assert++;
    if (pass !== (exp_err == 0)) begin
      n_fail++; $display("FAIL %s pass: got %0d required %0d", tag, pass, exp_err == 0);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) begin
      load(i, 8'(i + 1), 8'(i + 1), 8'hFF);
      resp[i] = 8'(i + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; start = 1'b0; num_vec = '0; dut_resp = '0;
    load_addr = '0; load_stim = '0; load_exp = '0; load_mask = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({stim_out, busy, done, pass, err_count, first_err_valid, first_err_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got stim=%h busy=%0d done=%0d pass=%0d err=%0d fev=%0d fei=%0d, required all zero",
               stim_out, busy, done, pass, err_count, first_err_valid, first_err_idx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic();
    do_run(4, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_single_error();
    resp[2] = 8'h13;
    do_run(4, 1'b0, 1'b0, "one_err");
    resp[2] = 8'h03;
  endtask

  task automatic test_mask();
    load(1, 8'h02, 8'h02, 8'h0F);
    resp[1] = 8'hF2;
    do_run(4, 1'b0, 1'b0, "mask_low");
    load(1, 8'h02, 8'h02, 8'hFF);
    do_run(4, 1'b0, 1'b0, "mask_full");
    load(2, 8'h03, 8'h03, 8'h00);
    resp[2] = 8'hC4;
    do_run(4, 1'b0, 1'b0, "mask_zero");
    load(2, 8'h03, 8'h03, 8'hFF);
    resp[1] = 8'h02; resp[2] = 8'h03;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) begin
      load(i, 8'(8'h10 + i), 8'(8'h20 + i), 8'hFF);
      resp[i] = ~m_exp[i];
    end
    do_run(8, 1'b0, 1'b0, "saturate");
  endtask

  task automatic test_zero_and_clamp();
    do_run(0, 1'b0, 1'b0, "zero_vec");
    for (int i = 0; i < DEPTH; i++) begin
      load(i, 8'($urandom), 8'($urandom), 8'hFF);
      resp[i] = m_exp[i];
    end
    resp[15] = ~m_exp[15];
    do_run(20, 1'b0, 1'b0, "clamp");
  endtask

  task automatic test_rst_midrun();
    load_basic();
    @(negedge clk);
    num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dut_resp = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if ({busy, done, err_count, first_err_valid} !== '0) begin
      n_fail++; $display("FAIL rst_midrun state: got busy=%0d done=%0d err=%0d fev=%0d, required zeros",
                         busy, done, err_count, first_err_valid);
    end
    repeat (5) begin
      dut_resp = 8'($urandom) | 8'h80;
      @(negedge clk);
    end
    n_assert++;
    if ({busy, done, err_count, first_err_valid} !== '0) begin
      n_fail++; $display("FAIL rst_flush late compares: got busy=%0d done=%0d err=%0d fev=%0d, required zeros",
                         busy, done, err_count, first_err_valid);
    end
    do_run(4, 1'b1, 1'b0, "after_rst_poke");
    do_run(4, 1'b0, 1'b0, "after_poke");
  endtask

  task automatic test_write_first();
    wf_stim = 8'hA5; wf_exp = 8'h5A; wf_mask = 8'hFF;
    resp[0] = 8'h5A;
    do_run(4, 1'b0, 1'b1, "write_first");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        load(i, 8'($urandom), 8'($urandom),
             ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
        resp[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_exp[i] ^ (8'($urandom) & ~m_mask[i]);
      end
      do_run($urandom_range(0, 20), 1'b0, 1'b0, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_error();
    test_mask();
    test_saturate();
    test_zero_and_clamp();
    test_rst_midrun();
    test_write_first();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
